reg_pipe_bank: RTL

Parametrised multi-channel register pipeline. It is the successor to the fixed two-channel, single-stage 8-bit register set: configurable width, channel count and depth, plus per-channel valid tracking, global stall, synchronous flush and saturating per-channel beat counters. It sits between producer and consumer logic wherever aligned, retimed multi-lane data with qualification is needed.

---
 rtl/reg_pipe_bank_pkg.sv | 19 +
 rtl/reg_pipe_lane.sv | 68 ++++++
 rtl/reg_pipe_bank.sv | 50 +++++
 3 files changed

// File: rtl/reg_pipe_bank_pkg.sv
// Shared types for the reg_pipe_bank register pipeline.
//   lane_op_e : per-cycle operation applied to every lane
//   lane_op() : folds the global stall/flush pair into one operation,
//               with flush taking priority over stall.
package reg_pipe_bank_pkg;

  typedef enum logic [1:0] {
    LANE_ADVANCE = 2'd0,
    LANE_STALL   = 2'd1,
    LANE_FLUSH   = 2'd2
  } lane_op_e;

  function automatic lane_op_e lane_op(input logic stall, input logic flush);
    if (flush) return LANE_FLUSH;
    if (stall) return LANE_STALL;
    return LANE_ADVANCE;
  endfunction

endpackage

// File: rtl/reg_pipe_lane.sv
// One channel of reg_pipe_bank: a DEPTH-deep shift of {valid, data} plus a
// saturating count of beats delivered from the last stage.
//   clk, rst   : clock, asynchronous active-low reset
//   op         : advance / stall / flush for this cycle
//   d, in_valid: stage-0 source
//   q, out_valid: last stage
//   beat_cnt   : delivered-beat count, saturates at all-ones
module reg_pipe_lane
  import reg_pipe_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  lane_op_e         op,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [CNT_W-1:0] cnt_r;

  // NOTE: non-blocking assignments let every stage read its neighbour's
  // pre-edge value, which is what makes the loop below a shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data array is reset as well so q reads 0, not X, after reset.
      for (int k = 0; k < DEPTH; k++) data_r[k] <= '0;
      valid_r <= '0;
      cnt_r   <= '0;
    end else begin
      unique case (op)
        LANE_FLUSH: begin
          // Data registers deliberately hold; only qualification is cleared.
          valid_r <= '0;
          cnt_r   <= '0;
        end
        LANE_ADVANCE: begin
          valid_r[0] <= in_valid;
          if (in_valid) data_r[0] <= d;
          for (int k = 1; k < DEPTH; k++) begin
            valid_r[k] <= valid_r[k-1];
            // Bubbles do not overwrite data, keeping toggling down.
            if (valid_r[k-1]) data_r[k] <= data_r[k-1];
          end
          // The beat currently at the output is delivered on this edge.
          if (valid_r[DEPTH-1] && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + 1'b1;
        end
        default: begin
          // Stall: everything holds.
        end
      endcase
    end
  end

  assign q         = data_r[DEPTH-1];
  assign out_valid = valid_r[DEPTH-1];
  assign beat_cnt  = cnt_r;

endmodule

// File: rtl/reg_pipe_bank.sv
// Parametrised multi-channel register pipeline. Slices the packed buses into
// NUM_CH independent reg_pipe_lane instances sharing stall/flush.
//   clk, rst  : clock, asynchronous active-low reset
//   d         : NUM_CH*WIDTH input data, channel c at [c*WIDTH +: WIDTH]
//   in_valid  : per-channel input qualifier
//   stall     : global hold
//   flush     : synchronous clear of valid bits and counters (beats stall)
//   q         : last-stage data, same packing as d
//   out_valid : last-stage valid per channel
//   beat_cnt  : per-channel delivered-beat count at [c*CNT_W +: CNT_W]
module reg_pipe_bank
  import reg_pipe_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] d,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*CNT_W-1:0] beat_cnt
);

  lane_op_e op;
  assign op = lane_op(stall, flush);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    reg_pipe_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .d         (d[c*WIDTH +: WIDTH]),
      .in_valid  (in_valid[c]),
      .q         (q[c*WIDTH +: WIDTH]),
      .out_valid (out_valid[c]),
      .beat_cnt  (beat_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule
